// File: rtl/dispatch_pkg.sv
// Shared definitions for the instruction dispatch unit: FSM state encoding,
// instruction word field positions and the halt flag index.
// No logic lives here; the decoder and top both import this package.
package dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Instruction word layout (32-bit word, MSB first):
    // [31:29] ALUOp | [28:26] dest | [25:23] src1 | [22:20] src2 |
    // [19] use_imm | [18] halt | [17:16] reserved | [15:0] imm
    localparam int WORD_BITS   = 32;
    localparam int ALUOP_LSB   = 29;
    localparam int DEST_LSB    = 26;
    localparam int SRC1_LSB    = 23;
    localparam int SRC2_LSB    = 20;
    localparam int USE_IMM_BIT = 19;
    localparam int HALT_BIT    = 18;
    localparam int RSVD_LSB    = 16;
    localparam int IMM_LSB     = 0;
    localparam int IMM_BITS    = 16;

endpackage

// File: rtl/dispatch_decode.sv
// Purpose : split one instruction word into reservation-station fields + halt flag.
// Latency : purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the decoded row is used.
//
// Ports:
//   i_word    : raw instruction word (SIZE bits, low 32 carry the encoding)
//   o_alu_op  : ALU opcode field
//   o_dest    : destination register index
//   o_src1    : first source register index
//   o_src2    : second source register index
//   o_use_imm : operand 2 comes from the immediate
//   o_imm     : 16-bit immediate sign-extended to SIZE
//   o_halt    : word terminates the program (it is still issued)
module dispatch_decode
    import dispatch_pkg::*;
#(
    parameter int SIZE       = 32,
    parameter int ALUOP_BITS = 3,
    parameter int RW         = 3
) (
    input  logic [SIZE-1:0]       i_word,
    output logic [ALUOP_BITS-1:0] o_alu_op,
    output logic [RW-1:0]         o_dest,
    output logic [RW-1:0]         o_src1,
    output logic [RW-1:0]         o_src2,
    output logic                  o_use_imm,
    output logic [SIZE-1:0]       o_imm,
    output logic                  o_halt
);

    logic [IMM_BITS-1:0] w_imm_raw;
    // Reserved bits carry no meaning today; named so they read as deliberately ignored.
    logic [1:0]          w_unused_rsvd;

    assign w_imm_raw     = i_word[IMM_LSB +: IMM_BITS];
    assign w_unused_rsvd = i_word[RSVD_LSB +: 2];

    assign o_alu_op  = i_word[ALUOP_LSB +: ALUOP_BITS];
    assign o_dest    = i_word[DEST_LSB +: RW];
    assign o_src1    = i_word[SRC1_LSB +: RW];
    assign o_src2    = i_word[SRC2_LSB +: RW];
    assign o_use_imm = i_word[USE_IMM_BIT];
    assign o_halt    = i_word[HALT_BIT];
    assign o_imm     = {{(SIZE-IMM_BITS){w_imm_raw[IMM_BITS-1]}}, w_imm_raw};

endmodule

// File: rtl/dispatch_unit.sv
// Purpose : fetch instruction words in program order and issue up to INPUT_ROWS
//           decoded rows per cycle into a reservation station.
// Latency : an issue decision taken on edge t is presented on the new_* outputs
//           after edge t, for exactly one cycle.
// Backpressure: station_free caps the issue width each cycle; 0 stalls with pc held.
//
// Ports:
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   start           : begin a program at address 0 (only looked at in IDLE)
//   prog_len        : number of words to dispatch (0..MEM_ROWS)
//   station_free    : free slots for next-cycle writes (values above INPUT_ROWS clamp)
//   imem_addr       : word address of row 0 (row r reads imem_addr+r mod MEM_ROWS)
//   imem_data       : combinational read data, one word per row
//   new_*           : registered decoded rows to the reservation station
//   new_valid       : per-row valid, always a contiguous run starting at row 0
//   busy / done     : busy while running; done pulses for the single DONE cycle
//   dispatched      : instructions issued since the last start
module dispatch_unit
    import dispatch_pkg::*;
#(
    parameter int SIZE       = 32,
    parameter int REG_NUM    = 8,
    parameter int ALUOP_BITS = 3,
    parameter int INPUT_ROWS = 2,
    parameter int MEM_ROWS   = 64
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic [$clog2(MEM_ROWS):0]                    prog_len,
    input  logic [1:0]                                   station_free,
    output logic [$clog2(MEM_ROWS)-1:0]                  imem_addr,
    input  logic [INPUT_ROWS-1:0][SIZE-1:0]              imem_data,
    output logic [INPUT_ROWS-1:0][ALUOP_BITS-1:0]        new_ALUOp,
    output logic [INPUT_ROWS-1:0][$clog2(REG_NUM)-1:0]   new_src_reg1,
    output logic [INPUT_ROWS-1:0][$clog2(REG_NUM)-1:0]   new_src_reg2,
    output logic [INPUT_ROWS-1:0]                        new_use_imm,
    output logic [INPUT_ROWS-1:0][SIZE-1:0]              new_imm,
    output logic [INPUT_ROWS-1:0][$clog2(REG_NUM)-1:0]   new_dest_reg1,
    output logic [INPUT_ROWS-1:0]                        new_valid,
    output logic                                         busy,
    output logic                                         done,
    output logic [$clog2(MEM_ROWS):0]                    dispatched
);

    localparam int AW = $clog2(MEM_ROWS);
    localparam int CW = AW + 1;
    localparam int RW = $clog2(REG_NUM);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                              r_state;
    state_t                              w_state_nxt;
    logic [AW-1:0]                       r_pc;
    logic [CW-1:0]                       r_dispatched;

    logic [INPUT_ROWS-1:0][ALUOP_BITS-1:0] r_new_alu;
    logic [INPUT_ROWS-1:0][RW-1:0]         r_new_src1;
    logic [INPUT_ROWS-1:0][RW-1:0]         r_new_src2;
    logic [INPUT_ROWS-1:0]                 r_new_use_imm;
    logic [INPUT_ROWS-1:0][SIZE-1:0]       r_new_imm;
    logic [INPUT_ROWS-1:0][RW-1:0]         r_new_dest;
    logic [INPUT_ROWS-1:0]                 r_new_valid;

    // ------------------------------------------------------------------
    // Decode of the rows currently presented by instruction memory
    // ------------------------------------------------------------------
    logic [INPUT_ROWS-1:0][ALUOP_BITS-1:0] w_alu;
    logic [INPUT_ROWS-1:0][RW-1:0]         w_dest;
    logic [INPUT_ROWS-1:0][RW-1:0]         w_src1;
    logic [INPUT_ROWS-1:0][RW-1:0]         w_src2;
    logic [INPUT_ROWS-1:0]                 w_use_imm;
    logic [INPUT_ROWS-1:0][SIZE-1:0]       w_imm;
    logic [INPUT_ROWS-1:0]                 w_halt;

    for (genvar g = 0; g < INPUT_ROWS; g++) begin : g_dec
        dispatch_decode #(
            .SIZE       (SIZE),
            .ALUOP_BITS (ALUOP_BITS),
            .RW         (RW)
        ) u_dec (
            .i_word    (imem_data[g]),
            .o_alu_op  (w_alu[g]),
            .o_dest    (w_dest[g]),
            .o_src1    (w_src1[g]),
            .o_src2    (w_src2[g]),
            .o_use_imm (w_use_imm[g]),
            .o_imm     (w_imm[g]),
            .o_halt    (w_halt[g])
        );
    end

    // ------------------------------------------------------------------
    // Issue width: min(station_free, remaining, INPUT_ROWS), then cut just
    // after the first halt so nothing past a halt word leaves the unit.
    // ------------------------------------------------------------------
    logic [CW-1:0]         w_remaining;
    logic [CW-1:0]         w_cap;
    logic [CW-1:0]         w_issue_n;
    logic                  w_halt_issued;
    logic [INPUT_ROWS-1:0] w_valid_mask;

    always_comb begin
        w_remaining = prog_len - r_dispatched;
        w_cap       = CW'(station_free);
        if (w_cap > CW'(INPUT_ROWS)) begin
            w_cap = CW'(INPUT_ROWS);
        end
        if (w_remaining < w_cap) begin
            w_cap = w_remaining;
        end
    end

    always_comb begin
        w_issue_n     = '0;
        w_halt_issued = 1'b0;
        if (r_state == ST_RUN) begin
            for (int r = 0; r < INPUT_ROWS; r++) begin
                if ((CW'(r) < w_cap) && !w_halt_issued) begin
                    w_issue_n = CW'(r + 1);
                    if (w_halt[r]) begin
                        w_halt_issued = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_valid_mask = '0;
        for (int r = 0; r < INPUT_ROWS; r++) begin
            w_valid_mask[r] = (CW'(r) < w_issue_n);
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // remaining==0 is judged before any issue this cycle, so a
                // zero-length program spends exactly one cycle in RUN.
                if ((w_remaining == '0) || w_halt_issued) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_RUN:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Program counter, issue count and registered output rows
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= '0;
            r_dispatched  <= '0;
            r_new_valid   <= '0;
            r_new_alu     <= '0;
            r_new_src1    <= '0;
            r_new_src2    <= '0;
            r_new_use_imm <= '0;
            r_new_imm     <= '0;
            r_new_dest    <= '0;
        end else begin
            // Mask is all-zero outside RUN, so valid drops after one cycle.
            r_new_valid <= w_valid_mask;

            if ((r_state == ST_IDLE) && start) begin
                r_pc         <= '0;
                r_dispatched <= '0;
            end else begin
                // pc is AW bits wide, so the add wraps mod MEM_ROWS.
                r_pc         <= r_pc + AW'(w_issue_n);
                r_dispatched <= r_dispatched + w_issue_n;
            end

            // Rows not issued keep their previous contents to avoid toggling.
            for (int r = 0; r < INPUT_ROWS; r++) begin
                if (w_valid_mask[r]) begin
                    r_new_alu[r]     <= w_alu[r];
                    r_new_src1[r]    <= w_src1[r];
                    r_new_src2[r]    <= w_src2[r];
                    r_new_use_imm[r] <= w_use_imm[r];
                    r_new_imm[r]     <= w_imm[r];
                    r_new_dest[r]    <= w_dest[r];
                end
            end
        end
    end

    assign imem_addr     = r_pc;
    assign dispatched    = r_dispatched;
    assign new_valid     = r_new_valid;
    assign new_ALUOp     = r_new_alu;
    assign new_src_reg1  = r_new_src1;
    assign new_src_reg2  = r_new_src2;
    assign new_use_imm   = r_new_use_imm;
    assign new_imm       = r_new_imm;
    assign new_dest_reg1 = r_new_dest;

endmodule

// File: tb/tb_dispatch_unit.sv
// Scoreboard bench for dispatch_unit: stimulus pushes the expected issue
// (cycle, valid mask, program index) and a negedge monitor pops and compares
// whenever new_valid is non-zero.
module tb_dispatch_unit;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic [6:0]            prog_len = '0;
    logic [1:0]            station_free = '0;
    logic [5:0]            imem_addr;
    logic [1:0][31:0]      imem_data;
    logic [1:0][2:0]       new_ALUOp;
    logic [1:0][2:0]       new_src_reg1;
    logic [1:0][2:0]       new_src_reg2;
    logic [1:0]            new_use_imm;
    logic [1:0][31:0]      new_imm;
    logic [1:0][2:0]       new_dest_reg1;
    logic [1:0]            new_valid;
    logic                  busy;
    logic                  done;
    logic [6:0]            dispatched;

    dispatch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .prog_len      (prog_len),
        .station_free  (station_free),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .new_ALUOp     (new_ALUOp),
        .new_src_reg1  (new_src_reg1),
        .new_src_reg2  (new_src_reg2),
        .new_use_imm   (new_use_imm),
        .new_imm       (new_imm),
        .new_dest_reg1 (new_dest_reg1),
        .new_valid     (new_valid),
        .busy          (busy),
        .done          (done),
        .dispatched    (dispatched)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- program image ----------------
    typedef struct packed {
        logic [2:0]  alu;
        logic [2:0]  dest;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic        ui;
        logic        halt;
        logic [15:0] imm;
        logic [31:0] ximm;   // expected sign-extended immediate
    } instr_t;

    instr_t      prog [64];
    logic [31:0] mem  [64];
    logic [5:0]  addr1;

    assign addr1        = imem_addr + 6'd1;
    assign imem_data[0] = mem[imem_addr];
    assign imem_data[1] = mem[addr1];

    function automatic logic [31:0] enc(input instr_t i);
        return {i.alu, i.dest, i.s1, i.s2, i.ui, i.halt, 2'b00, i.imm};
    endfunction

    task automatic load_mem();
        for (int i = 0; i < 64; i++) mem[i] = enc(prog[i]);
    endtask

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    typedef struct {
        logic [1:0] vld;
        int         idx;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    task automatic push(input logic [1:0] vld, input int idx, input int c);
        exp_t e;
        e.vld = vld; e.idx = idx; e.cyc = c;
        sb.push_back(e);
    endtask

    function automatic logic [44:0] dut_row(input int r);
        return {new_ALUOp[r], new_dest_reg1[r], new_src_reg1[r], new_src_reg2[r],
                new_use_imm[r], new_imm[r]};
    endfunction

    function automatic logic [44:0] exp_row(input int idx);
        return {prog[idx].alu, prog[idx].dest, prog[idx].s1, prog[idx].s2,
                prog[idx].ui, prog[idx].ximm};
    endfunction

    always @(negedge clk) begin
        if (!rst && new_valid !== 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_issue", 64'(new_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("issue_cycle", 64'(cyc), 64'(e.cyc));
                chk("valid_mask", 64'(new_valid), 64'(e.vld));
                chk("row0_fields", 64'(dut_row(0)), 64'(exp_row(e.idx)));
                if (e.vld[1]) chk("row1_fields", 64'(dut_row(1)), 64'(exp_row(e.idx + 1)));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len, input logic [1:0] sf, output int s);
        prog_len     = 7'(len);
        station_free = sf;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        s            = cyc;
    endtask

    task automatic wait_done(input int maxc, input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        chk(name, 64'(found), 64'd1);
    endtask

    task automatic finish_run(input int exp_disp, input string name);
        chk({name, "_dispatched"}, 64'(dispatched), 64'(exp_disp));
        start = 1'b0;
        tick();
        chk({name, "_done_one_cycle"}, 64'(done), 64'd0);
        chk({name, "_idle_not_busy"}, 64'(busy), 64'd0);
        chk({name, "_sb_drained"}, 64'(sb.size()), 64'd0);
    endtask

    int s;

    initial begin
        // Program: four hand-built words, the rest from a simple pattern.
        for (int i = 0; i < 64; i++) begin
            prog[i].alu  = 3'(i);
            prog[i].dest = 3'(i + 3);
            prog[i].s1   = 3'(i + 1);
            prog[i].s2   = 3'(i + 2);
            prog[i].ui   = i[0];
            prog[i].halt = 1'b0;
            prog[i].imm  = 16'(i * 16'h0911);
            prog[i].ximm = {{16{prog[i].imm[15]}}, prog[i].imm};
        end
        prog[0] = '{alu: 3'd1, dest: 3'd1, s1: 3'd2, s2: 3'd3, ui: 1'b0, halt: 1'b0,
                    imm: 16'h0005, ximm: 32'h0000_0005};
        prog[1] = '{alu: 3'd2, dest: 3'd4, s1: 3'd5, s2: 3'd6, ui: 1'b1, halt: 1'b0,
                    imm: 16'h8000, ximm: 32'hFFFF_8000};
        prog[2] = '{alu: 3'b101, dest: 3'd7, s1: 3'd0, s2: 3'd2, ui: 1'b1, halt: 1'b0,
                    imm: 16'hFFFF, ximm: 32'hFFFF_FFFF};
        prog[3] = '{alu: 3'd3, dest: 3'd2, s1: 3'd1, s2: 3'd0, ui: 1'b0, halt: 1'b0,
                    imm: 16'h1234, ximm: 32'h0000_1234};
        load_mem();

        // Reset state
        tick(); tick();
        chk("rst_new_valid", 64'(new_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dispatched", 64'(dispatched), 64'd0);
        chk("rst_imem_addr", 64'(imem_addr), 64'd0);
        chk("rst_new_imm0", 64'(new_imm[0]), 64'd0);
        chk("rst_new_alu1", 64'(new_ALUOp[1]), 64'd0);
        rst = 1'b0;
        tick(); tick();
        chk("idle_busy", 64'(busy), 64'd0);

        // Four words, two free slots: two full-width issues
        do_start(4, 2'd2, s);
        chk("run_busy", 64'(busy), 64'd1);
        push(2'b11, 0, s + 1);
        push(2'b11, 2, s + 2);
        wait_done(10, "len4_done");
        finish_run(4, "len4");

        // Odd length: full issue, then single row starting at word 2
        do_start(3, 2'd2, s);
        push(2'b11, 0, s + 1);
        push(2'b01, 2, s + 2);
        wait_done(10, "len3_done");
        finish_run(3, "len3");

        // Credit throttling: 1,1 then stall for three cycles, then 2
        do_start(4, 2'd1, s);
        push(2'b01, 0, s + 1);
        push(2'b01, 1, s + 2);
        push(2'b11, 2, s + 6);
        tick(); tick();
        station_free = 2'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", 64'(imem_addr), 64'd2);
        end
        chk("stall_dispatched", 64'(dispatched), 64'd2);
        station_free = 2'd2;
        wait_done(10, "stall_done");
        finish_run(4, "stall");

        // Halt in word 1: one issue of words 0-1, then DONE
        prog[1].halt = 1'b1; load_mem();
        do_start(8, 2'd2, s);
        push(2'b11, 0, s + 1);
        wait_done(10, "halt1_done");
        finish_run(2, "halt1");
        prog[1].halt = 1'b0;

        // Halt in word 0: only row 0 goes out even with room for two
        prog[0].halt = 1'b1; load_mem();
        do_start(8, 2'd2, s);
        push(2'b01, 0, s + 1);
        wait_done(10, "halt0_done");
        finish_run(1, "halt0");
        prog[0].halt = 1'b0; load_mem();

        // Zero-length program: no issue, straight to DONE
        do_start(0, 2'd2, s);
        wait_done(5, "len0_done");
        finish_run(0, "len0");

        // start held high through the run must not restart it
        prog_len = 7'd4; station_free = 2'd2; start = 1'b1;
        tick();
        s = cyc;
        push(2'b11, 0, s + 1);
        push(2'b11, 2, s + 2);
        wait_done(10, "held_done");
        finish_run(4, "held");
        tick(); tick();
        chk("held_no_restart", 64'(busy), 64'd0);

        // Full memory, station_free=3 clamps to 2; pc wraps back to 0
        do_start(64, 2'd3, s);
        for (int k = 0; k < 32; k++) push(2'b11, 2 * k, s + 1 + k);
        wait_done(50, "full_done");
        chk("full_pc_wrap", 64'(imem_addr), 64'd0);
        finish_run(64, "full");

        // Reset mid-run: outputs clear at once, then restart from word 0
        do_start(10, 2'd2, s);
        push(2'b11, 0, s + 1);
        push(2'b11, 2, s + 2);
        tick(); tick();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_new_valid", 64'(new_valid), 64'd0);
        chk("midrst_pc", 64'(imem_addr), 64'd0);
        chk("midrst_dispatched", 64'(dispatched), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_imm", 64'(new_imm[0]), 64'd0);
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("postrst_idle", 64'(busy), 64'd0);
        do_start(2, 2'd2, s);
        push(2'b11, 0, s + 1);
        wait_done(10, "restart_done");
        finish_run(2, "restart");

        tick(); tick();
        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dispatch_unit.md
DISPATCH_UNIT -- requirements
Module: dispatch_unit

Interface
REQ-001 SHALL have parameters SIZE=32 (data/imm width), REG_NUM=8 (register count), ALUOP_BITS=3 (opcode width), INPUT_ROWS=2 (dispatch rows per cycle), MEM_ROWS=64 (instruction memory depth).
REQ-002 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-003 start  in  1  begin dispatching from address 0; sampled only in IDLE.
REQ-004 prog_len  in  $clog2(MEM_ROWS)+1  number of instruction words to dispatch (0..MEM_ROWS).
REQ-005 station_free  in  2  free reservation-station slots available for next-cycle writes (0..2).
REQ-006 imem_addr  out  $clog2(MEM_ROWS)  word address of row 0; row 1 = imem_addr+1, computed mod MEM_ROWS.
REQ-007 imem_data  in  INPUT_ROWS x SIZE  combinational read data, row r = word at imem_addr+r.
REQ-008 new_ALUOp, new_src_reg1, new_src_reg2, new_use_imm, new_imm, new_dest_reg1  out  INPUT_ROWS x field width  decoded instruction rows to the reservation station.
REQ-009 new_valid  out  INPUT_ROWS  per-row valid; row 1 never valid unless row 0 is valid.
REQ-010 busy  out  1  high in RUN; done  out  1  one-cycle pulse on entry to DONE.
REQ-011 dispatched  out  $clog2(MEM_ROWS)+1  count of instructions issued since start.

Function
REQ-012 Word format: [31:29] ALUOp, [28:26] dest, [25:23] src1, [22:20] src2, [19] use_imm, [18] halt, [15:0] imm; imm SHALL be sign-extended to SIZE.
REQ-013 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE when remaining=0 or a halt word is issued; DONE->IDLE unconditionally after one cycle.
REQ-014 In RUN, issue count n = min(station_free, remaining, 2), further limited so that no word after a halt word is issued; a halt word SHALL itself be issued.
REQ-015 Issue is in program order: row 0 = word at pc, row 1 = word at pc+1; new_valid = 2'b00, 2'b01 or 2'b11 for n = 0, 1, 2.
REQ-016 All new_* outputs SHALL be registered: a decision at edge t appears at edge t+1 for exactly one cycle; new_valid = 0 in every other cycle.
REQ-017 pc and dispatched SHALL both advance by n on the issuing edge; remaining = prog_len - dispatched.
REQ-018 imem_addr = pc; pc wraps mod MEM_ROWS, and row 1 at pc=MEM_ROWS-1 reads address 0.
REQ-019 station_free=0 SHALL stall with pc held and new_valid=0; station_free>2 SHALL be treated as 2.
REQ-020 prog_len=0 with start: RUN lasts one cycle, no issue, then DONE.
REQ-021 Field values on invalid rows are don't-care but SHALL hold their last values (no toggling).
REQ-022 start asserted in RUN or DONE SHALL be ignored.

Reset
REQ-023 rst SHALL asynchronously force: state=IDLE, pc=0, dispatched=0, new_valid=0, all new_* fields=0, busy=0, done=0.
REQ-024 rst asserted mid-RUN SHALL discard in-flight issue; after release the unit waits in IDLE for start.

Structure
REQ-025 Package dispatch_pkg SHALL hold the state enum, word field bit positions, and the halt bit index.
REQ-026 Sub-module dispatch_decode (combinational, word -> fields + halt) SHALL be instantiated INPUT_ROWS times.

Verification
REQ-027 prog_len=4, station_free=2, no halts, start -> new_valid 2'b11 at cycles 2 and 3, done pulse, dispatched=4.
REQ-028 prog_len=3, station_free=2 -> 2'b11 then 2'b01; row 0 of the second issue is word 2.
REQ-029 prog_len=4, station_free=1 for 2 cycles, then 0 for 3 cycles, then 2 -> 01, 01, stall with pc=2, then 11.
REQ-030 Word 1 halt, prog_len=8, station_free=2 -> single 2'b11 issue (words 0-1), DONE, dispatched=2.
REQ-031 Word encoding ALUOp=101, src2=2, use_imm=1, imm=16'hFFFF -> new_ALUOp=3'b101, new_src_reg2=2, new_imm=32'hFFFFFFFF.
REQ-032 rst pulsed mid-RUN with prog_len=10 -> new_valid=0 immediately, pc=0; a later start restarts issue at word 0.
